// File: rtl/trackball_quad_encoder.sv
// trackball_quad_encoder
//
// Turns signed per-axis motion deltas into the step trains an arcade
// trackball or spinner input expects. Each axis accumulates incoming deltas
// and drains the accumulator one count per step opportunity. Each step
// advances a small phase counter that is decoded to either {dir, clk} or
// 2-bit Gray quadrature {a, b}.
//
// Build option:
//   TRACKBALL_GRAY_EN  defined   -> mode_i selects {dir,clk} (0) or Gray {a,b} (1)
//                      undefined -> mode_i is ignored, the output is always {dir,clk},
//                                   and the upper phase bit is not built
//
// Ports:
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset (deassert synchronously to clk_sys)
//   delta_valid  one-cycle strobe that loads delta_i for all axes
//   delta_i      signed deltas, axis k at [k*DELTA_W +: DELTA_W]
//   invert_i     per-axis negate of the incoming delta
//   rate_i       step period minus one (0 = a step opportunity every cycle)
//   mode_i       0 = {dir, clk}, 1 = Gray {a, b}
//   clear_i      synchronous clear of the accumulators and the prescaler
//   quad_o       axis k at [2k+1:2k]
//   busy_o       accumulator of axis k is non-zero
//   sat_o        one-cycle pulse after axis k clamped on update

module trackball_quad_encoder #(
    parameter int AXES    = 2,
    parameter int ACC_W   = 12,
    parameter int DELTA_W = 9,
    parameter int DIV_W   = 8
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      delta_valid,
    input  logic [AXES*DELTA_W-1:0]   delta_i,
    input  logic [AXES-1:0]           invert_i,
    input  logic [DIV_W-1:0]          rate_i,
    input  logic                      mode_i,
    input  logic                      clear_i,
    output logic [2*AXES-1:0]         quad_o,
    output logic [AXES-1:0]           busy_o,
    output logic [AXES-1:0]           sat_o
);

    // The sum acc + step + d is formed two bits wider than the accumulator so
    // that neither the largest delta nor the step can wrap before clamping.
    localparam int EXT_W = ACC_W + 2;
    localparam logic signed [EXT_W-1:0] ACC_MAX = {{3{1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN = -ACC_MAX;

`ifdef TRACKBALL_GRAY_EN
    localparam int PH_W = 2;
`else
    localparam int PH_W = 1;
    logic unused_mode_s;
    assign unused_mode_s = mode_i;
`endif

    logic [DIV_W-1:0] cnt_r;
    logic             tick_s;

    // A rate lowered below the running count yields an immediate tick.
    assign tick_s = (cnt_r >= rate_i);

    // Shared step-rate prescaler, restarted by clear.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (clear_i) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < AXES; g++) begin : g_axis
        logic signed [ACC_W-1:0]   acc_r;
        logic [PH_W-1:0]           phase_r;
        logic                      dir_r;
        logic                      sat_r;
        logic signed [DELTA_W-1:0] dk_s;
        logic signed [EXT_W-1:0]   d_s;
        logic signed [EXT_W-1:0]   step_s;
        logic signed [EXT_W-1:0]   sum_s;
        logic signed [ACC_W-1:0]   acc_next_s;
        logic                      clamp_s;
        logic                      step_up_s;
        logic                      step_dn_s;
        logic [1:0]                quad_s;

        assign dk_s = delta_i[g*DELTA_W +: DELTA_W];

        // Step decision from the registered accumulator, delta add and clamp.
        always_comb begin
            step_up_s  = tick_s && !acc_r[ACC_W-1] && (acc_r != {ACC_W{1'b0}});
            step_dn_s  = tick_s && acc_r[ACC_W-1];
            d_s        = {EXT_W{1'b0}};
            step_s     = {EXT_W{1'b0}};
            acc_next_s = acc_r;
            clamp_s    = 1'b0;
            if (delta_valid) begin
                if (invert_i[g]) begin
                    d_s = -EXT_W'(dk_s);
                end else begin
                    d_s = EXT_W'(dk_s);
                end
            end else begin
                d_s = {EXT_W{1'b0}};
            end
            // Positive motion drains downwards, negative motion upwards.
            if (step_up_s) begin
                step_s = {EXT_W{1'b1}};
            end else if (step_dn_s) begin
                step_s = EXT_W'(1);
            end else begin
                step_s = {EXT_W{1'b0}};
            end
            sum_s = EXT_W'(acc_r) + step_s + d_s;
            if (sum_s > ACC_MAX) begin
                acc_next_s = ACC_MAX[ACC_W-1:0];
                clamp_s    = 1'b1;
            end else if (sum_s < ACC_MIN) begin
                acc_next_s = ACC_MIN[ACC_W-1:0];
                clamp_s    = 1'b1;
            end else begin
                acc_next_s = sum_s[ACC_W-1:0];
                clamp_s    = 1'b0;
            end
        end

        // Per-axis state; clear empties the accumulator but holds phase and dir
        // so the output lines do not glitch.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                acc_r   <= {ACC_W{1'b0}};
                phase_r <= {PH_W{1'b0}};
                dir_r   <= 1'b0;
                sat_r   <= 1'b0;
            end else if (clear_i) begin
                acc_r   <= {ACC_W{1'b0}};
                sat_r   <= 1'b0;
            end else begin
                acc_r <= acc_next_s;
                sat_r <= clamp_s;
                if (step_up_s) begin
                    dir_r   <= 1'b1;
                    phase_r <= phase_r + PH_W'(1);
                end else if (step_dn_s) begin
                    dir_r   <= 1'b0;
                    phase_r <= phase_r - PH_W'(1);
                end else begin
                    dir_r   <= dir_r;
                    phase_r <= phase_r;
                end
            end
        end

`ifdef TRACKBALL_GRAY_EN
        // Gray decode walks 00,01,11,10 as the phase counts up.
        assign quad_s = mode_i ? {phase_r[1], phase_r[1] ^ phase_r[0]}
                               : {dir_r, phase_r[0]};
`else
        assign quad_s = {dir_r, phase_r[0]};
`endif

        assign quad_o[2*g +: 2] = quad_s;
        assign busy_o[g]        = (acc_r != {ACC_W{1'b0}});
        assign sat_o[g]         = sat_r;
    end

endmodule

// File: doc/trackball_quad_encoder.md
# trackball_quad_encoder

Converts signed mouse-style motion deltas into the quadrature or direction/clock pulse trains that arcade trackball and spinner inputs expect. It generalises the fixed two-axis, 12-bit trackball emulation in the emu top level to N axes, a configurable accumulator width and a programmable step rate. It adds symmetric saturation and an optional true 2-bit Gray quadrature mode. It sits between hps_io's ps2_mouse decode and the game core's trackball input bus, in the clk_sys domain.

## Interface
- AXES, 2: number of independent axes.
- ACC_W, 12: signed accumulator width per axis (>= DELTA_W+1).
- DELTA_W, 9: signed delta width per axis (PS/2: sign + 8 bits).
- DIV_W, 8: step-rate prescaler width.

- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- delta_valid  in  1  one-cycle strobe; loads all axes' deltas.
- delta_i  in  AXES*DELTA_W  two's-complement deltas; axis k at [k*DELTA_W +: DELTA_W].
- invert_i  in  AXES  per-axis negate of incoming delta (screen flip).
- rate_i  in  DIV_W  step period minus 1; 0 = one step opportunity per cycle.
- mode_i  in  1  0 = {dir, clk} encoding, 1 = Gray quadrature {a, b}.
- clear_i  in  1  synchronous clear of accumulators and prescaler.
- quad_o  out  2*AXES  axis k at [2k+1:2k]; mode 0: {dir, clk}; mode 1: {a, b}.
- busy_o  out  AXES  accumulator of axis k non-zero.
- sat_o  out  AXES  one-cycle pulse when axis k clamped on update.

## Operation
- Per-axis state: acc (signed ACC_W), phase (2 bits), dir (1 bit). One shared prescaler cnt (DIV_W).
- Prescaler: tick = (cnt >= rate_i). On tick cnt <= 0, otherwise cnt <= cnt+1. A rate_i lowered below cnt yields an immediate tick.
- Step decision on tick, per axis, from the registered acc:
  - acc > 0: step = -1, dir <= 1, phase <= phase+1.
  - acc < 0: step = +1, dir <= 0, phase <= phase-1.
  - acc == 0: no change.
- Delta add: d = sign-extend(delta_i[k]), negated when invert_i[k]. d applies only while delta_valid is high.
- Update: next = acc + step + d, computed at ACC_W+2 bits.
  - Clamp to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)].
  - sat_o[k] is high in the cycle after a clamp occurs.
  - A simultaneous tick and delta both apply in the same cycle.
- clear_i has priority over delta_valid and tick:
  - acc <= 0 and cnt <= 0.
  - phase and dir hold, so quad_o does not move.
- Output decode is combinational from flops only, with no input-to-output path:
  - mode 0: {dir, phase[0]}.
  - mode 1: {phase[1], phase[1]^phase[0]}, giving the sequence 00,01,11,10 for positive motion.
- Changing mode_i re-encodes quad_o immediately; no state is lost.
- busy_o[k] = (acc != 0).

## Timing
- Reset (reset_n low, asynchronous) drives:
  - acc = 0, phase = 00, dir = 0, cnt = 0.
  - quad_o = 0 and busy_o = 0 for all axes.
  - sat_o = 0.
- delta_valid sampled at edge N: acc and busy_o are valid after edge N.
- First step occurs at the first tick at or after edge N+1. quad_o changes right after that tick's edge.
- Step rate: one edge per axis every rate_i+1 cycles while busy.
- Drain time for |acc| = M: M*(rate_i+1) cycles when no further deltas arrive.
- Deassertion of reset_n must be synchronised externally to clk_sys.

## Configuration
- TRACKBALL_GRAY_EN defined: mode_i is honoured and Gray quadrature is available.
- TRACKBALL_GRAY_EN undefined:
  - mode_i is ignored and quad_o is always {dir, phase[0]}.
  - phase[1] and the Gray logic are removed.

## Test plan
- Reset with AXES=2: quad_o=4'b0000, busy_o=2'b00, sat_o=2'b00. After release with no input, all outputs are unchanged for 100 cycles.
- rate_i=0, mode 0, axis0 delta +5:
  - busy_o[0] high for 5 cycles, then low.
  - quad_o[1] (dir) = 1; quad_o[0] toggles 5 times and ends at 1.
  - axis1 outputs stay static.
- rate_i=3, axis1 delta -2: two clk toggles, 4 cycles apart, with dir=0. acc returns to 0 after 8 cycles.
- mode 1 (TRACKBALL_GRAY_EN), rate_i=0:
  - axis0 delta +4 → {a,b} = 01,11,10,00.
  - Then delta -1 → 10.
  - Switching mode_i to 0 mid-drain changes only the encoding.
- ACC_W=12, rate_i=255: nine strobes of +255 on axis0.
  - acc clamps at 2047.
  - sat_o[0] pulses exactly once, on the ninth update.
  - invert_i[0]=1 with delta +3 then gives acc=2044.
- Simultaneous tick and delta_valid, with acc=+1 and delta +2 → acc=+2. clear_i asserted with delta_valid → acc=0, quad_o held.
